// File: rtl/coffee_dispenser.sv
// Actuator sequencer behind the vending controller: cup, pour, optional flavour shot,
// plus an independent coin-ejector engine that pays out captured change tokens.
module coffee_dispenser #(
    parameter int unsigned CUP_CYCLES      = 4,
    parameter int unsigned POUR_CYCLES     = 16,
    parameter int unsigned FLAVOUR_CYCLES  = 8,
    parameter int unsigned COIN_ON_CYCLES  = 2,
    parameter int unsigned COIN_GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dispense,
    input  logic [2:0] coffee_select,
    input  logic [7:0] change_tokens,
    output logic       dispense_done,
    output logic       cup_drop,
    output logic       pump_on,
    output logic [1:0] flavour_valve,
    output logic       coin_out,
    output logic       disp_busy,
    output logic       change_busy,
    output logic       sel_error
);

    // Handshake: dispense is a level request held until dispense_done is seen.
    // dispense_done pulses for one cycle; a new request is taken only from S_IDLE.

    localparam logic [15:0] CUP_LOAD      = 16'(CUP_CYCLES - 1);
    localparam logic [15:0] POUR_LOAD     = 16'(POUR_CYCLES - 1);
    localparam logic [15:0] FLAVOUR_LOAD  = 16'(FLAVOUR_CYCLES - 1);
    localparam logic [15:0] COIN_ON_LOAD  = 16'(COIN_ON_CYCLES - 1);
    localparam logic [15:0] COIN_GAP_LOAD = 16'(COIN_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CUP,
        S_POUR,
        S_FLAVOUR,
        S_DONE,
        S_RELEASE
    } disp_state_e;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ON,
        C_GAP
    } coin_state_e;

    disp_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  sel_q, sel_d;
    logic        sel_error_q, sel_error_d;

    coin_state_e cstate_q, cstate_d;
    logic [15:0] ccnt_q, ccnt_d;
    logic [7:0]  change_q;
    logic [7:0]  pending_q, pending_d;

    logic        sel_valid;
    logic        sel_flavoured;
    logic        load_evt;
    logic        coin_dec;
    logic [9:0]  pending_sum;

    assign sel_valid     = (coffee_select >= 3'd1) && (coffee_select <= 3'd3);
    assign sel_flavoured = (sel_q == 3'd2) || (sel_q == 3'd3);

    // ---------------- dispense sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            sel_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            sel_error_q <= sel_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        sel_error_d = sel_error_q;
        case (state_q)
            S_IDLE: begin
                if (dispense) begin
                    sel_d       = coffee_select;
                    sel_error_d = 1'b0;
                    if (sel_valid) begin
                        state_d = S_CUP;
                        cnt_d   = CUP_LOAD;
                    end else begin
                        // Invalid selections complete immediately so the controller is never stuck.
                        sel_error_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_CUP: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_POUR;
                    cnt_d   = POUR_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_POUR: begin
                if (cnt_q == 16'd0) begin
                    if (sel_flavoured) begin
                        state_d = S_FLAVOUR;
                        cnt_d   = FLAVOUR_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_FLAVOUR: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!dispense) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        flavour_valve = 2'b00;
        if (state_q == S_FLAVOUR) begin
            if (sel_q == 3'd2) begin
                flavour_valve = 2'b01;
            end else if (sel_q == 3'd3) begin
                flavour_valve = 2'b10;
            end
        end
    end

    assign cup_drop      = (state_q == S_CUP);
    assign pump_on       = (state_q == S_POUR);
    assign dispense_done = (state_q == S_DONE);
    assign disp_busy     = (state_q != S_IDLE);
    assign sel_error     = sel_error_q;

    // ---------------- change capture and payout ----------------
    // Only the first nonzero cycle of a burst counts, so a held value loads once.
    assign load_evt = (change_tokens != 8'd0) && (change_q == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cstate_q  <= C_IDLE;
            ccnt_q    <= '0;
            change_q  <= '0;
            pending_q <= '0;
        end else begin
            cstate_q  <= cstate_d;
            ccnt_q    <= ccnt_d;
            change_q  <= change_tokens;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        cstate_d = cstate_q;
        ccnt_d   = ccnt_q;
        coin_dec = 1'b0;
        case (cstate_q)
            C_IDLE: begin
                if (pending_q != 8'd0) begin
                    cstate_d = C_ON;
                    ccnt_d   = COIN_ON_LOAD;
                    coin_dec = 1'b1;
                end
            end
            C_ON: begin
                if (ccnt_q == 16'd0) begin
                    cstate_d = C_GAP;
                    ccnt_d   = COIN_GAP_LOAD;
                end else begin
                    ccnt_d = ccnt_q - 16'd1;
                end
            end
            C_GAP: begin
                if (ccnt_q == 16'd0) begin
                    if (pending_q != 8'd0) begin
                        cstate_d = C_ON;
                        ccnt_d   = COIN_ON_LOAD;
                        coin_dec = 1'b1;
                    end else begin
                        cstate_d = C_IDLE;
                    end
                end else begin
                    ccnt_d = ccnt_q - 16'd1;
                end
            end
            default: begin
                cstate_d = C_IDLE;
            end
        endcase
    end

    // Add and decrement in one sum so a load landing on a coin entry loses neither.
    always_comb begin
        pending_sum = {2'b00, pending_q}
                    + (load_evt ? {2'b00, change_tokens} : 10'd0)
                    - {9'd0, coin_dec};
        pending_d   = (pending_sum > 10'd255) ? 8'd255 : pending_sum[7:0];
    end

    assign coin_out    = (cstate_q == C_ON);
    assign change_busy = (pending_q != 8'd0) || (cstate_q != C_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0({cup_drop, pump_on, (flavour_valve != 2'b00)}))
                else $error("actuators overlap");
            assert (flavour_valve != 2'b11)
                else $error("both flavour valves open");
        end
    end

endmodule

// File: tb/tb_coffee_dispenser.sv
// Directed bench for coffee_dispenser: table of dispense vectors checked cycle by cycle,
// plus hand-written change payout, saturation and reset sequences.
module tb_coffee_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       dispense;
    logic [2:0] coffee_select;
    logic [7:0] change_tokens;
    logic       dispense_done;
    logic       cup_drop;
    logic       pump_on;
    logic [1:0] flavour_valve;
    logic       coin_out;
    logic       disp_busy;
    logic       change_busy;
    logic       sel_error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [2:0] sel;
        logic [2:0] sel_late;
        bit         drop_early;
        int         done_k;
        logic [1:0] flav;
        logic       err;
    } disp_vec_t;

    disp_vec_t vecs[7];

    coffee_dispenser dut (
        .clk           (clk),
        .reset         (reset),
        .dispense      (dispense),
        .coffee_select (coffee_select),
        .change_tokens (change_tokens),
        .dispense_done (dispense_done),
        .cup_drop      (cup_drop),
        .pump_on       (pump_on),
        .flavour_valve (flavour_valve),
        .coin_out      (coin_out),
        .disp_busy     (disp_busy),
        .change_busy   (change_busy),
        .sel_error     (sel_error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        dispense      = 1'b0;
        coffee_select = 3'd0;
        change_tokens = 8'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_vector(input int idx, input disp_vec_t v);
        logic       e_cup, e_pump, e_done, e_busy, valid;
        logic [1:0] e_flav;
        coffee_select = v.sel;
        dispense      = 1'b1;
        step();
        for (int k = 1; k <= v.done_k + 3; k++) begin
            valid  = !v.err;
            e_cup  = valid && (k >= 1) && (k <= 4);
            e_pump = valid && (k >= 5) && (k <= 20);
            e_flav = (valid && (k >= 21) && (k <= 28)) ? v.flav : 2'b00;
            e_done = (k == v.done_k);
            e_busy = (k <= v.done_k + 1);
            check($sformatf("vec%0d_k%0d {done,cup,pump,flav,busy,err}", idx, k),
                  {26'd0, dispense_done, cup_drop, pump_on, flavour_valve, disp_busy, sel_error},
                  {26'd0, e_done, e_cup, e_pump, e_flav, e_busy, v.err});
            if (k == 10) coffee_select = v.sel_late;
            if (v.drop_early && k == 3) dispense = 1'b0;
            if (k == v.done_k + 1) dispense = 1'b0;
            step();
        end
    endtask

    // One-shot (hold_k=1) or held token burst; expected {coin_out, change_busy} per cycle.
    task automatic run_coins(input string name, input int n, input int hold_k);
        logic [1:0] got, exp;
        exp_q.delete();
        for (int k = 1; k <= 4 * n + 4; k++) begin
            exp_q.push_back({(k >= 2) && (k < 2 + 4 * n) && (((k - 2) % 4) < 2),
                             (k <= 4 * n + 1)});
        end
        change_tokens = 8'(n);
        step();
        for (int k = 1; k <= 4 * n + 4; k++) begin
            got = {coin_out, change_busy};
            exp = exp_q.pop_front();
            check($sformatf("%s_k%0d {coin,cbusy}", name, k), {30'd0, got}, {30'd0, exp});
            if (k == hold_k) change_tokens = 8'd0;
            step();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int done_cnt;
        int first_done;
        int late_cup;
        int pulses;
        logic prev;

        vecs[0] = '{3'd1, 3'd1, 1'b0, 21, 2'b00, 1'b0};
        vecs[1] = '{3'd3, 3'd1, 1'b0, 29, 2'b10, 1'b0};
        vecs[2] = '{3'd2, 3'd1, 1'b0, 29, 2'b01, 1'b0};
        vecs[3] = '{3'd0, 3'd0, 1'b0, 1,  2'b00, 1'b1};
        vecs[4] = '{3'd1, 3'd2, 1'b1, 21, 2'b00, 1'b0};
        vecs[5] = '{3'd7, 3'd7, 1'b0, 1,  2'b00, 1'b1};
        vecs[6] = '{3'd3, 3'd3, 1'b1, 29, 2'b10, 1'b0};

        apply_reset();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle%0d outputs", i),
                  {23'd0, dispense_done, cup_drop, pump_on, flavour_valve, coin_out,
                   disp_busy, change_busy, sel_error},
                  32'd0);
            step();
        end

        for (int i = 0; i < 7; i++) begin
            run_vector(i, vecs[i]);
        end

        // Request held high past DONE must not restart the sequence.
        coffee_select = 3'd1;
        dispense      = 1'b1;
        done_cnt      = 0;
        first_done    = 0;
        late_cup      = 0;
        step();
        for (int k = 1; k <= 40; k++) begin
            if (dispense_done) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            if (k > 21 && (cup_drop || pump_on)) late_cup++;
            step();
        end
        check("held_done_count", 32'(done_cnt), 32'd1);
        check("held_done_cycle", 32'(first_done), 32'd21);
        check("held_no_restart", 32'(late_cup), 32'd0);
        check("held_busy", {31'd0, disp_busy}, 32'd1);
        dispense = 1'b0;
        step();
        step();
        check("held_release_idle", {31'd0, disp_busy}, 32'd0);

        // Reset mid-pour drops the pump on the next edge.
        coffee_select = 3'd2;
        dispense      = 1'b1;
        step();
        for (int k = 1; k < 8; k++) step();
        check("midpour_pump_on", {31'd0, pump_on}, 32'd1);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        dispense = 1'b0;
        check("midpour_reset outputs", {28'd0, pump_on, disp_busy, flavour_valve}, 32'd0);
        step();

        run_coins("coin3", 3, 1);
        run_coins("coin2_held", 2, 4);

        // Load landing on the same edge as a coin entry keeps both updates.
        change_tokens = 8'd2;
        pulses        = 0;
        prev          = 1'b0;
        step();
        for (int k = 1; k <= 40; k++) begin
            if (coin_out && !prev) pulses++;
            prev = coin_out;
            if (k == 1) change_tokens = 8'd0;
            if (k == 5) change_tokens = 8'd1;
            if (k == 6) change_tokens = 8'd0;
            step();
        end
        check("coincide_pulses", 32'(pulses), 32'd3);
        check("coincide_cbusy", {31'd0, change_busy}, 32'd0);

        // Saturation, then reset in the middle of payout.
        change_tokens = 8'd254;
        step();
        change_tokens = 8'd0;
        step();
        change_tokens = 8'd5;
        step();
        change_tokens = 8'd0;
        check("sat_pending", {24'd0, dut.pending_q}, 32'd255);
        check("sat_coin_active", {31'd0, coin_out}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("sat_reset coin", {31'd0, coin_out}, 32'd0);
        check("sat_reset cbusy", {31'd0, change_busy}, 32'd0);
        check("sat_reset pending", {24'd0, dut.pending_q}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (coin_out) pulses++;
            step();
        end
        check("sat_reset_no_pulses", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
